// File: rtl/ccu_wb_burst_gen_if.sv
// AXI write-channel bundle (AW/W/B) between the line-writeback burst
// generator (master) and the memory-side write port (slave).
interface ccu_wb_burst_gen_if #(
    parameter int unsigned AxiAddrWidth = 64,
    parameter int unsigned AxiDataWidth = 64,
    parameter int unsigned AxiIdWidth   = 4
);
    logic                      aw_valid;
    logic                      aw_ready;
    logic [AxiAddrWidth-1:0]   aw_addr;
    logic [7:0]                aw_len;
    logic [2:0]                aw_size;
    logic [1:0]                aw_burst;
    logic [AxiIdWidth-1:0]     aw_id;

    logic                      w_valid;
    logic                      w_ready;
    logic [AxiDataWidth-1:0]   w_data;
    logic [AxiDataWidth/8-1:0] w_strb;
    logic                      w_last;

    logic                      b_valid;
    logic                      b_ready;
    logic [AxiIdWidth-1:0]     b_id;

    modport master (
        output aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id,
        input  aw_ready,
        output w_valid, w_data, w_strb, w_last,
        input  w_ready,
        input  b_valid, b_id,
        output b_ready
    );

    modport slave (
        input  aw_valid, aw_addr, aw_len, aw_size, aw_burst, aw_id,
        output aw_ready,
        input  w_valid, w_data, w_strb, w_last,
        output w_ready,
        output b_valid, b_id,
        input  b_ready
    );
endinterface

// File: rtl/ccu_wb_burst_gen.sv
// Dirty-line writeback burst generator: buffers lines in a small FIFO and
// turns each into one AXI INCR write burst, bounding unacknowledged writes.
module ccu_wb_burst_gen #(
    parameter int unsigned DcacheLineWidth = 512,
    parameter int unsigned AxiDataWidth    = 64,
    parameter int unsigned AxiAddrWidth    = 64,
    parameter int unsigned AxiIdWidth      = 4,
    parameter int unsigned Depth           = 2,
    parameter int unsigned MaxOutstanding  = 4
) (
    input  logic                                clk_i,
    input  logic                                rst_i,
    input  logic                                req_valid_i,
    output logic                                req_ready_o,
    input  logic [AxiAddrWidth-1:0]             req_addr_i,
    input  logic [DcacheLineWidth-1:0]          req_data_i,
    input  logic [AxiIdWidth-1:0]               req_id_i,
    ccu_wb_burst_gen_if.master                  axi,
    output logic                                done_o,
    output logic [AxiIdWidth-1:0]               done_id_o,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic                                busy_o
);

    localparam int unsigned Ratio           = DcacheLineWidth / AxiDataWidth;
    localparam int unsigned WbAxLen         = ((Ratio > 1) ? Ratio : 1) - 1;
    localparam int unsigned WbAxSize        = $clog2(AxiDataWidth / 8);
    localparam int unsigned LineOffset      = $clog2(DcacheLineWidth / 8);
    localparam int unsigned WbAddrAlignment = (LineOffset > WbAxSize) ? LineOffset : WbAxSize;
    localparam int unsigned BeatW           = (WbAxLen > 0) ? $clog2(WbAxLen + 1) : 1;
    localparam int unsigned PtrW            = (Depth > 1) ? $clog2(Depth) : 1;
    localparam int unsigned CntW            = $clog2(Depth + 1);
    localparam int unsigned OutW            = $clog2(MaxOutstanding + 1);
    localparam int unsigned StrbW           = AxiDataWidth / 8;

    localparam logic [AxiAddrWidth-1:0] AddrMask =
        ~((AxiAddrWidth'(1) << WbAddrAlignment) - AxiAddrWidth'(1));

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_BURST = 1'b1;

    logic [AxiAddrWidth-1:0]    addr_mem_q [Depth];
    logic [DcacheLineWidth-1:0] data_mem_q [Depth];
    logic [AxiIdWidth-1:0]      id_mem_q   [Depth];

    logic [PtrW-1:0]  wr_ptr_q, wr_ptr_d;
    logic [PtrW-1:0]  rd_ptr_q, rd_ptr_d;
    logic [PtrW-1:0]  aw_ptr_q, aw_ptr_d;
    logic [CntW-1:0]  count_q, count_d;
    logic [CntW-1:0]  aw_cnt_q, aw_cnt_d;
    logic [BeatW-1:0] beat_q, beat_d;
    logic [OutW-1:0]  out_q, out_d;
    logic [0:0]       state_q, state_d;
    logic             ready_q;
    logic             done_q;
    logic [AxiIdWidth-1:0] done_id_q;

    logic full, push, pop, last;
    logic aw_pending, out_full;
    logic aw_hs, w_hs, b_hs;

    function automatic logic [PtrW-1:0] ptr_inc(input logic [PtrW-1:0] p);
        if (p == PtrW'(Depth - 1)) return '0;
        return p + PtrW'(1);
    endfunction

    // Ready comes only from registered state so AXI backpressure never
    // reaches the request side combinationally.
    assign full        = (count_q == CntW'(Depth));
    assign req_ready_o = ready_q & ~full;
    assign push        = req_valid_i & req_ready_o;

    // aw_cnt_q counts buffered entries whose AW has already been accepted.
    assign aw_pending   = (aw_cnt_q != count_q);
    assign out_full     = (out_q == OutW'(MaxOutstanding));
    assign axi.aw_valid = aw_pending & (~out_full | axi.b_valid);
    assign axi.aw_addr  = addr_mem_q[aw_ptr_q] & AddrMask;
    assign axi.aw_len   = 8'(WbAxLen);
    assign axi.aw_size  = 3'(WbAxSize);
    assign axi.aw_burst = 2'b01;
    assign axi.aw_id    = id_mem_q[aw_ptr_q];
    assign aw_hs        = axi.aw_valid & axi.aw_ready;

    // In IDLE the AW candidate is the head entry, so its W may start alongside.
    assign axi.w_valid = (state_q == ST_BURST) | aw_hs;
    assign last        = (beat_q == BeatW'(WbAxLen));
    assign axi.w_last  = last;
    assign w_hs        = axi.w_valid & axi.w_ready;
    assign pop         = w_hs & last;

    assign axi.b_ready = (out_q != '0);
    assign b_hs        = axi.b_valid & axi.b_ready;

    generate
        if (DcacheLineWidth < AxiDataWidth) begin : g_narrow
            localparam int unsigned LineBytes = DcacheLineWidth / 8;
            logic [WbAxSize-LineOffset-1:0] lane;
            assign lane       = addr_mem_q[rd_ptr_q][WbAxSize-1:LineOffset];
            assign axi.w_data = {(AxiDataWidth / DcacheLineWidth){data_mem_q[rd_ptr_q]}};
            assign axi.w_strb = StrbW'({LineBytes{1'b1}}) << (32'(lane) * LineBytes);
        end else begin : g_wide
            logic [AxiDataWidth-1:0] beats [WbAxLen+1];
            always_comb begin
                for (int unsigned k = 0; k <= WbAxLen; k++) begin
                    beats[k] = data_mem_q[rd_ptr_q][k*AxiDataWidth +: AxiDataWidth];
                end
            end
            assign axi.w_data = beats[beat_q];
            assign axi.w_strb = '1;
        end
    endgenerate

    always_comb begin
        wr_ptr_d = push  ? ptr_inc(wr_ptr_q) : wr_ptr_q;
        rd_ptr_d = pop   ? ptr_inc(rd_ptr_q) : rd_ptr_q;
        aw_ptr_d = aw_hs ? ptr_inc(aw_ptr_q) : aw_ptr_q;
        count_d  = count_q + CntW'(push) - CntW'(pop);
        aw_cnt_d = aw_cnt_q + CntW'(aw_hs) - CntW'(pop);
        out_d    = out_q + OutW'(aw_hs) - OutW'(b_hs);

        beat_d = beat_q;
        if (w_hs) beat_d = last ? '0 : beat_q + BeatW'(1);

        // Checking aw_cnt_d also covers a single-beat burst that completes
        // in the same cycle as its AW handshake.
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (aw_cnt_d != '0) state_d = ST_BURST;
            ST_BURST: if (pop && aw_cnt_d == '0) state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            aw_ptr_q  <= '0;
            count_q   <= '0;
            aw_cnt_q  <= '0;
            beat_q    <= '0;
            out_q     <= '0;
            state_q   <= ST_IDLE;
            ready_q   <= 1'b0;
            done_q    <= 1'b0;
            done_id_q <= '0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            aw_ptr_q  <= aw_ptr_d;
            count_q   <= count_d;
            aw_cnt_q  <= aw_cnt_d;
            beat_q    <= beat_d;
            out_q     <= out_d;
            state_q   <= state_d;
            ready_q   <= 1'b1;
            done_q    <= b_hs;
            done_id_q <= axi.b_id;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) begin
            addr_mem_q[wr_ptr_q] <= req_addr_i;
            data_mem_q[wr_ptr_q] <= req_data_i;
            id_mem_q[wr_ptr_q]   <= req_id_i;
        end
    end

    assign done_o        = done_q;
    assign done_id_o     = done_id_q;
    assign outstanding_o = out_q;
    assign busy_o        = (count_q != '0) | (out_q != '0);

endmodule
